// File: rtl/midi_voice_in.sv
// MIDI serial receiver and monophonic Note On/Off decoder driving gate, note, velocity and freq.
// Optional: define MIDI_VOICE_IN_OMNI_EN to decode channel messages on all 16 channels.

package mypackage;
  localparam int FREQUENCY_WIDTH = 24;
  localparam int FREQUENCY_FRACTIONAL_BITS = 8;
  typedef logic [FREQUENCY_WIDTH-1:0] frequency;
endpackage

module midi_voice_in
  import mypackage::*;
#(
  parameter int CLOCK_HZ     = 50_000_000,
  parameter int BAUD         = 31250,
  parameter int MIDI_CHANNEL = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       midi_rx,
  output logic       gate,
  output logic [6:0] note,
  output logic [6:0] velocity,
  output frequency   freq,
  output logic       framing_error
);

  localparam int BIT_CYCLES = CLOCK_HZ / BAUD;
  localparam int CW = $clog2(BIT_CYCLES + 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] HALF_LOAD = CW'(BIT_CYCLES / 2 - 1);
  localparam logic [3:0] CHANNEL = 4'(MIDI_CHANNEL);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic {WAIT_D1, WAIT_D2} parse_state_t;

  // Equal-tempered pitch of MIDI note n, fixed point, rounded and saturated.
  function automatic frequency note_freq(input int n);
    real hz;
    real scaled;
    real max_val;
    hz      = 440.0 * (2.0 ** (real'(n - 69) / 12.0));
    scaled  = hz * (2.0 ** FREQUENCY_FRACTIONAL_BITS);
    max_val = (2.0 ** FREQUENCY_WIDTH) - 1.0;
    if (scaled + 0.5 >= max_val) begin
      return '1;
    end
    return frequency'($rtoi(scaled + 0.5));
  endfunction

  frequency freq_rom [0:127];

  for (genvar gi = 0; gi < 128; gi++) begin : g_rom
    localparam frequency ENTRY = note_freq(gi);
    assign freq_rom[gi] = ENTRY;
  end

  logic rx_meta_q;
  logic rx_sync_q;
  logic rx_prev_q;

  rx_state_t rx_state_q, rx_state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [7:0] shift_q, shift_d;
  logic       byte_strobe_q, byte_strobe_d;
  logic [7:0] rx_byte_q, rx_byte_d;
  logic       framing_error_q, framing_error_d;

  parse_state_t parse_state_q, parse_state_d;
  logic [7:0] status_q, status_d;
  logic [6:0] d1_q, d1_d;

  logic       gate_q, gate_d;
  logic [6:0] note_q, note_d;
  logic [6:0] velocity_q, velocity_d;
  frequency   freq_q, freq_d;

  // Receiver: prev/sync falling edge arms a frame, so after a framing
  // error the line must return high before a new start bit is seen.
  always_comb begin
    rx_state_d      = rx_state_q;
    cnt_d           = cnt_q;
    bit_idx_d       = bit_idx_q;
    shift_d         = shift_q;
    byte_strobe_d   = 1'b0;
    rx_byte_d       = rx_byte_q;
    framing_error_d = 1'b0;

    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_d = RX_START;
          cnt_d      = HALF_LOAD;
        end
      end
      RX_START: begin
        if (cnt_q == '0) begin
          if (!rx_sync_q) begin
            rx_state_d = RX_DATA;
            cnt_d      = FULL_LOAD;
            bit_idx_d  = 3'd0;
          end else begin
            rx_state_d = RX_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == '0) begin
          shift_d = {rx_sync_q, shift_q[7:1]};
          cnt_d   = FULL_LOAD;
          if (bit_idx_q == 3'd7) begin
            rx_state_d = RX_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == '0) begin
          rx_state_d = RX_IDLE;
          if (rx_sync_q) begin
            byte_strobe_d = 1'b1;
            rx_byte_d     = shift_q;
          end else begin
            framing_error_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  logic       chan_ok;
  logic       two_byte;
  logic       msg_done;
  logic [6:0] msg_d1;
  logic [6:0] msg_d2;

  always_comb begin
`ifdef MIDI_VOICE_IN_OMNI_EN
    chan_ok = 1'b1;
`else
    chan_ok = (status_q[3:0] == CHANNEL);
`endif
    two_byte = (status_q[7:4] != 4'hC) && (status_q[7:4] != 4'hD);

    parse_state_d = parse_state_q;
    status_d      = status_q;
    d1_d          = d1_q;
    msg_done      = 1'b0;
    msg_d1        = 7'd0;
    msg_d2        = 7'd0;

    if (byte_strobe_q) begin
      if (rx_byte_q[7]) begin
        if (rx_byte_q[7:3] == 5'b11111) begin
          // Realtime bytes pass through without disturbing any message.
        end else if (rx_byte_q[7:4] == 4'hF) begin
          status_d      = 8'h00;
          parse_state_d = WAIT_D1;
        end else begin
          status_d      = rx_byte_q;
          parse_state_d = WAIT_D1;
        end
      end else if (status_q[7]) begin
        if (parse_state_q == WAIT_D1) begin
          if (two_byte) begin
            d1_d          = rx_byte_q[6:0];
            parse_state_d = WAIT_D2;
          end else begin
            msg_done = 1'b1;
            msg_d1   = rx_byte_q[6:0];
          end
        end else begin
          msg_done      = 1'b1;
          msg_d1        = d1_q;
          msg_d2        = rx_byte_q[6:0];
          parse_state_d = WAIT_D1;
        end
      end
    end
  end

  always_comb begin
    gate_d     = gate_q;
    note_d     = note_q;
    velocity_d = velocity_q;
    freq_d     = freq_q;

    if (msg_done && chan_ok) begin
      if ((status_q[7:4] == 4'h9) && (msg_d2 != 7'd0)) begin
        gate_d     = 1'b1;
        note_d     = msg_d1;
        velocity_d = msg_d2;
        freq_d     = freq_rom[msg_d1];
      end else if ((status_q[7:4] == 4'h8) || (status_q[7:4] == 4'h9)) begin
        // Only the sounding note can release; pitch is held for the release phase.
        if (gate_q && (msg_d1 == note_q)) begin
          gate_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_meta_q       <= 1'b1;
      rx_sync_q       <= 1'b1;
      rx_prev_q       <= 1'b1;
      rx_state_q      <= RX_IDLE;
      cnt_q           <= '0;
      bit_idx_q       <= 3'd0;
      shift_q         <= 8'h00;
      byte_strobe_q   <= 1'b0;
      rx_byte_q       <= 8'h00;
      framing_error_q <= 1'b0;
      parse_state_q   <= WAIT_D1;
      status_q        <= 8'h00;
      d1_q            <= 7'd0;
      gate_q          <= 1'b0;
      note_q          <= 7'd0;
      velocity_q      <= 7'd0;
      freq_q          <= '0;
    end else begin
      rx_meta_q       <= midi_rx;
      rx_sync_q       <= rx_meta_q;
      rx_prev_q       <= rx_sync_q;
      rx_state_q      <= rx_state_d;
      cnt_q           <= cnt_d;
      bit_idx_q       <= bit_idx_d;
      shift_q         <= shift_d;
      byte_strobe_q   <= byte_strobe_d;
      rx_byte_q       <= rx_byte_d;
      framing_error_q <= framing_error_d;
      parse_state_q   <= parse_state_d;
      status_q        <= status_d;
      d1_q            <= d1_d;
      gate_q          <= gate_d;
      note_q          <= note_d;
      velocity_q      <= velocity_d;
      freq_q          <= freq_d;
    end
  end

  assign gate          = gate_q;
  assign note          = note_q;
  assign velocity      = velocity_q;
  assign freq          = freq_q;
  assign framing_error = framing_error_q;

endmodule

// File: tb/tb_midi_voice_in.sv
// Directed bench for midi_voice_in: bit-banged MIDI bytes with hand-computed expectations.
// Runs with a 16-cycle bit period so the whole sequence stays short.

module tb_midi_voice_in;

  localparam int CLOCK_HZ = 500_000;
  localparam int BAUD     = 31250;
  localparam int BIT      = CLOCK_HZ / BAUD;

  // TABLE values with 8 fraction bits: 440*256, 523.2511*256, 261.6256*256, 329.6276*256
  localparam logic [31:0] F69 = 32'd112640;
  localparam logic [31:0] F72 = 32'd133952;
  localparam logic [31:0] F60 = 32'd66976;
  localparam logic [31:0] F64 = 32'd84385;

`ifdef MIDI_VOICE_IN_OMNI_EN
  localparam logic [31:0] CH_NOTE = 32'd64;
  localparam logic [31:0] CH_VEL  = 32'd64;
  localparam logic [31:0] CH_FREQ = F64;
`else
  localparam logic [31:0] CH_NOTE = 32'd60;
  localparam logic [31:0] CH_VEL  = 32'd80;
  localparam logic [31:0] CH_FREQ = F60;
`endif

  logic clk;
  logic rst;
  logic rx;
  logic gate;
  logic [6:0] note;
  logic [6:0] velocity;
  mypackage::frequency freq;
  logic framing_error;

  int tests;
  int failed;
  int fe_count;
  int fe_base;

  midi_voice_in #(
    .CLOCK_HZ(CLOCK_HZ),
    .BAUD(BAUD),
    .MIDI_CHANNEL(0)
  ) dut (
    .clock(clk),
    .reset(rst),
    .midi_rx(rx),
    .gate(gate),
    .note(note),
    .velocity(velocity),
    .freq(freq),
    .framing_error(framing_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial fe_count = 0;
  always @(posedge clk) begin
    if (framing_error === 1'b1) fe_count <= fe_count + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send_head(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT) @(negedge clk);
    end
    rx = stop;
  endtask

  task automatic send_tail();
    repeat (BIT) @(negedge clk);
    rx = 1'b1;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_head(b, 1'b1);
    send_tail();
  endtask

  task automatic check_voice(input string tag, input logic [31:0] g, input logic [31:0] n,
                             input logic [31:0] v, input logic [31:0] f);
    check({tag, ".gate"}, 32'(gate), g);
    check({tag, ".note"}, 32'(note), n);
    check({tag, ".velocity"}, 32'(velocity), v);
    check({tag, ".freq"}, 32'(freq), f);
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    rst    = 1'b1;
    rx     = 1'b1;
    repeat (4) @(negedge clk);
    check_voice("reset", 0, 0, 0, 0);
    check("reset.framing_error", 32'(framing_error), 0);
    rst = 1'b0;
    repeat (BIT) @(negedge clk);

    // Note On with a latency window around the final stop bit
    send_byte(8'h90);
    send_byte(8'h45);
    send_head(8'h64, 1'b1);
    repeat (6) @(negedge clk);
    check("noteon.gate_early", 32'(gate), 0);
    repeat (BIT - 6) @(negedge clk);
    check_voice("noteon", 1, 69, 100, F69);
    rx = 1'b1;
    repeat (BIT) @(negedge clk);

    send_byte(8'h48);
    send_byte(8'h40);
    check_voice("running", 1, 72, 64, F72);

    send_byte(8'h45);
    send_byte(8'h00);
    check_voice("release_other", 1, 72, 64, F72);

    send_byte(8'h48);
    send_byte(8'h00);
    check_voice("release_held", 0, 72, 64, F72);

    send_byte(8'h90);
    send_byte(8'hF8);
    send_byte(8'h3C);
    send_byte(8'hFE);
    send_byte(8'h50);
    check_voice("realtime", 1, 60, 80, F60);

    send_byte(8'hF0);
    send_byte(8'h40);
    send_byte(8'h40);
    check_voice("sysex", 1, 60, 80, F60);

    send_byte(8'h91);
    send_byte(8'h40);
    send_byte(8'h40);
    check_voice("channel", 1, CH_NOTE, CH_VEL, CH_FREQ);

    // Framing error after running status was cleared
    send_byte(8'hF0);
    fe_base = fe_count;
    send_head(8'h90, 1'b0);
    send_tail();
    check("framing.pulses", 32'(fe_count - fe_base), 1);
    send_byte(8'h45);
    send_byte(8'h64);
    check_voice("framing.dropped", 1, CH_NOTE, CH_VEL, CH_FREQ);

    // Short low glitch on the line
    fe_base = fe_count;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (3 * BIT) @(negedge clk);
    check("glitch.pulses", 32'(fe_count - fe_base), 0);
    check_voice("glitch", 1, CH_NOTE, CH_VEL, CH_FREQ);

    // Reset asserted mid data bit 3 of a Note On status byte
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = 1'(8'h90 >> i);
      repeat (BIT) @(negedge clk);
    end
    rx = 1'b0;
    repeat (BIT / 2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_voice("async_reset", 0, 0, 0, 0);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2 * BIT) @(negedge clk);

    send_byte(8'h90);
    send_byte(8'h3C);
    send_byte(8'h7F);
    check_voice("after_reset", 1, 60, 127, F60);

    send_byte(8'h80);
    send_byte(8'h3C);
    send_byte(8'h10);
    check_voice("noteoff", 0, 60, 127, F60);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
